emc_port_input_sync: RTL and testbench

- Input conditioning stage between the pad ring and the core. It takes the raw pad receive buses (top_p0_y..top_p3_y) and delivers metastability-safe port values to the core.
- On the P3 alternate-function pins it adds a glitch filter and 8051-style external interrupt flags for INT0/INT1 on P3.2/P3.3.
- It also generates timer count pulses for T0/T1 on P3.4/P3.5.
- It sits directly downstream of the pad block and upstream of the CPU core, SFR and timer logic.

---
 rtl/emc_port_input_sync_if.sv | 52 +++++
 rtl/emc_port_input_sync.sv | 130 +++++++++++++
 tb/tb_emc_port_input_sync.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/emc_port_input_sync_if.sv
//------------------------------------------------------------------------------
// Module  : emc_port_input_sync_if
// Brief   : Pad-to-core bundle for the port input conditioning stage.
//           Optional wake output present when EMC_PORT_WAKEUP_EN is defined.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface emc_port_input_sync_if;
  logic [7:0] top_p0_y_i;
  logic [7:0] top_p1_y_i;
  logic [7:0] top_p2_y_i;
  logic [7:0] top_p3_y_i;
  logic [7:0] sync_p0_o;
  logic [7:0] sync_p1_o;
  logic [7:0] sync_p2_o;
  logic [7:0] sync_p3_o;
  logic       it0_i;
  logic       it1_i;
  logic       ie0_clr_i;
  logic       ie1_clr_i;
  logic       ie0_o;
  logic       ie1_o;
  logic       t0_pulse_o;
  logic       t1_pulse_o;
`ifdef EMC_PORT_WAKEUP_EN
  logic       wake_o;
`endif

  // master: pad ring / core side; slave: the conditioning block
  modport master (
    output top_p0_y_i, top_p1_y_i, top_p2_y_i, top_p3_y_i,
    output it0_i, it1_i, ie0_clr_i, ie1_clr_i,
    input  sync_p0_o, sync_p1_o, sync_p2_o, sync_p3_o,
    input  ie0_o, ie1_o, t0_pulse_o, t1_pulse_o
`ifdef EMC_PORT_WAKEUP_EN
    , input wake_o
`endif
  );

  modport slave (
    input  top_p0_y_i, top_p1_y_i, top_p2_y_i, top_p3_y_i,
    input  it0_i, it1_i, ie0_clr_i, ie1_clr_i,
    output sync_p0_o, sync_p1_o, sync_p2_o, sync_p3_o,
    output ie0_o, ie1_o, t0_pulse_o, t1_pulse_o
`ifdef EMC_PORT_WAKEUP_EN
    , output wake_o
`endif
  );
endinterface

`default_nettype wire

// File: rtl/emc_port_input_sync.sv
//------------------------------------------------------------------------------
// Module  : emc_port_input_sync
// Brief   : Pad synchronisers, INT0/INT1 glitch filter + interrupt flags and
//           T0/T1 count pulses. Define EMC_PORT_WAKEUP_EN to add wake_o.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module emc_port_input_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic                  top_clock_i,
  input  logic                  top_reset_i,
  emc_port_input_sync_if.slave  bus
);

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
      $error("emc_port_input_sync: SYNC_STAGES must be in 2..4");
    end
    if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
      $error("emc_port_input_sync: FILTER_LEN must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] c_filter_len = 4'(FILTER_LEN);

  logic [31:0] w_pads;
  logic [31:0] w_sync;
  logic [31:0] r_sync [SYNC_STAGES];

  assign w_pads = {bus.top_p3_y_i, bus.top_p2_y_i, bus.top_p1_y_i, bus.top_p0_y_i};

  // Chains idle high to match the port pull-ups
  always_ff @(posedge top_clock_i or posedge top_reset_i) begin
    if (top_reset_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '1;
    end else begin
      r_sync[0] <= w_pads;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_sync        = r_sync[SYNC_STAGES-1];
  assign bus.sync_p0_o = w_sync[7:0];
  assign bus.sync_p1_o = w_sync[15:8];
  assign bus.sync_p2_o = w_sync[23:16];
  assign bus.sync_p3_o = w_sync[31:24];

  logic [1:0] w_tmr_sync;
  logic [1:0] r_tmr_hist;
  logic [1:0] r_tmr_pulse;

  assign w_tmr_sync = w_sync[29:28];

  always_ff @(posedge top_clock_i or posedge top_reset_i) begin
    if (top_reset_i) begin
      r_tmr_hist  <= 2'b11;
      r_tmr_pulse <= 2'b00;
    end else begin
      r_tmr_hist  <= w_tmr_sync;
      r_tmr_pulse <= r_tmr_hist & ~w_tmr_sync;
    end
  end

  assign bus.t0_pulse_o = r_tmr_pulse[0];
  assign bus.t1_pulse_o = r_tmr_pulse[1];

  logic [1:0] w_int_sync;
  logic [1:0] w_mode;
  logic [1:0] w_clr;
  logic [1:0] w_filt;
  logic [1:0] w_ie;

  assign w_int_sync = w_sync[27:26];
  assign w_mode     = {bus.it1_i, bus.it0_i};
  assign w_clr      = {bus.ie1_clr_i, bus.ie0_clr_i};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_int
      logic       r_filt;
      logic       r_filt_d;
      logic       r_ie;
      logic [3:0] r_cnt;

      always_ff @(posedge top_clock_i or posedge top_reset_i) begin
        if (top_reset_i) begin
          r_filt   <= 1'b1;
          r_filt_d <= 1'b1;
          r_cnt    <= 4'd0;
          r_ie     <= 1'b0;
        end else begin
          r_filt_d <= r_filt;
          if (w_int_sync[gi] == r_filt) begin
            r_cnt <= 4'd0;
          end else if (r_cnt + 4'd1 == c_filter_len) begin
            r_filt <= w_int_sync[gi];
            r_cnt  <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
          // Edge mode: a filtered fall outranks a same-cycle acknowledge
          if (w_mode[gi]) begin
            if (r_filt_d && !r_filt) r_ie <= 1'b1;
            else if (w_clr[gi])      r_ie <= 1'b0;
          end else begin
            r_ie <= ~r_filt;
          end
        end
      end

      assign w_filt[gi] = r_filt;
      assign w_ie[gi]   = r_ie;
    end
  endgenerate

  assign bus.ie0_o = w_ie[0];
  assign bus.ie1_o = w_ie[1];

`ifdef EMC_PORT_WAKEUP_EN
  assign bus.wake_o = ~w_filt[0] | ~w_filt[1];
`else
  logic w_unused;
  assign w_unused = ^{w_filt, w_sync};
`endif

endmodule

`default_nettype wire

// File: tb/tb_emc_port_input_sync.sv
//------------------------------------------------------------------------------
// Module  : tb_emc_port_input_sync
// Brief   : Directed and randomized bench with a sample-window reference model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_emc_port_input_sync;
  localparam int SS = 2;
  localparam int FL = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  emc_port_input_sync_if bus ();

  emc_port_input_sync #(.SYNC_STAGES(SS), .FILTER_LEN(FL)) dut (
    .top_clock_i (clk),
    .top_reset_i (rst),
    .bus         (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int t0_cnt   = 0;
  int t1_cnt   = 0;

  // Reference state: pad history, synchronised outputs, recent sync samples
  logic [31:0] m_hist [SS];
  logic [31:0] m_sync, m_sync_prev;
  logic [31:0] m_samp [$];
  logic        m_f [2];
  logic        m_fp [2];
  logic        m_ie [2];
  logic [1:0]  m_pulse;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [31:0] pads,
                            input logic [1:0] it, input logic [1:0] clr);
    logic [31:0] s_pre, s_pre2;
    logic        all_diff, new_f;
    if (r) begin
      for (int i = 0; i < SS; i++) m_hist[i] = '1;
      m_sync = '1; m_sync_prev = '1; m_samp.delete();
      for (int p = 0; p < 2; p++) begin m_f[p] = 1'b1; m_fp[p] = 1'b1; m_ie[p] = 1'b0; end
      m_pulse = 2'b00;
      return;
    end
    s_pre  = m_sync;
    s_pre2 = m_sync_prev;
    m_pulse = s_pre2[29:28] & ~s_pre[29:28];
    m_samp.push_back(s_pre);
    if (m_samp.size() > FL) void'(m_samp.pop_front());
    for (int p = 0; p < 2; p++) begin
      if (it[p]) begin
        if (m_fp[p] && !m_f[p]) m_ie[p] = 1'b1;
        else if (clr[p])        m_ie[p] = 1'b0;
      end else begin
        m_ie[p] = ~m_f[p];
      end
      // Filtered value flips once the last FL samples all disagree with it
      new_f = m_f[p];
      if (m_samp.size() == FL) begin
        all_diff = 1'b1;
        for (int j = 0; j < FL; j++) if (m_samp[j][26+p] == m_f[p]) all_diff = 1'b0;
        if (all_diff) new_f = ~m_f[p];
      end
      m_fp[p] = m_f[p];
      m_f[p]  = new_f;
    end
    for (int i = SS-1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0]   = pads;
    m_sync_prev = m_sync;
    m_sync      = m_hist[SS-1];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge(rst, {bus.top_p3_y_i, bus.top_p2_y_i, bus.top_p1_y_i, bus.top_p0_y_i},
               {bus.it1_i, bus.it0_i}, {bus.ie1_clr_i, bus.ie0_clr_i});
    check("sync_p0", 32'(bus.sync_p0_o), 32'(m_sync[7:0]));
    check("sync_p1", 32'(bus.sync_p1_o), 32'(m_sync[15:8]));
    check("sync_p2", 32'(bus.sync_p2_o), 32'(m_sync[23:16]));
    check("sync_p3", 32'(bus.sync_p3_o), 32'(m_sync[31:24]));
    check("ie0", 32'(bus.ie0_o), 32'(m_ie[0]));
    check("ie1", 32'(bus.ie1_o), 32'(m_ie[1]));
    check("t0_pulse", 32'(bus.t0_pulse_o), 32'(m_pulse[0]));
    check("t1_pulse", 32'(bus.t1_pulse_o), 32'(m_pulse[1]));
`ifdef EMC_PORT_WAKEUP_EN
    check("wake", 32'(bus.wake_o), 32'(~m_f[0] | ~m_f[1]));
`endif
    if (bus.t0_pulse_o === 1'b1) t0_cnt++;
    if (bus.t1_pulse_o === 1'b1) t1_cnt++;
  endtask

  initial begin
    logic [7:0] p3;
    bus.top_p0_y_i = 8'h00; bus.top_p1_y_i = 8'h00;
    bus.top_p2_y_i = 8'h00; bus.top_p3_y_i = 8'h00;
    bus.it0_i = 1'b0; bus.it1_i = 1'b0;
    bus.ie0_clr_i = 1'b0; bus.ie1_clr_i = 1'b0;

    // Reset with all pads low
    repeat (3) tick();
    check("rst_sync_p0", 32'(bus.sync_p0_o), 32'hFF);
    check("rst_ie0", 32'(bus.ie0_o), 32'h0);
    check("rst_t0", 32'(bus.t0_pulse_o), 32'h0);
    rst = 1'b0;
    tick(); tick();
    check("release_sync_p0", 32'(bus.sync_p0_o), 32'h00);

    bus.top_p0_y_i = 8'hFF; bus.top_p1_y_i = 8'hFF;
    bus.top_p2_y_i = 8'hFF; bus.top_p3_y_i = 8'hFF;
    bus.it0_i = 1'b1; bus.it1_i = 1'b1;
    repeat (12) tick();
    bus.ie0_clr_i = 1'b1; bus.ie1_clr_i = 1'b1;
    tick();
    bus.ie0_clr_i = 1'b0; bus.ie1_clr_i = 1'b0;
    tick();
    check("idle_ie0", 32'(bus.ie0_o), 32'h0);
    check("idle_ie1", 32'(bus.ie1_o), 32'h0);

    // Synchroniser latency
    bus.top_p1_y_i = 8'hA5;
    tick();
    check("p1_lat1", 32'(bus.sync_p1_o), 32'hFF);
    tick();
    check("p1_lat2", 32'(bus.sync_p1_o), 32'hA5);

    // INT0 edge mode: 2-cycle glitch then sustained low
    bus.top_p3_y_i[2] = 1'b0; tick(); tick();
    bus.top_p3_y_i[2] = 1'b1; repeat (8) tick();
    check("glitch_no_ie0", 32'(bus.ie0_o), 32'h0);
    bus.top_p3_y_i[2] = 1'b0;
    repeat (5) tick();
    check("ie0_before_set", 32'(bus.ie0_o), 32'h0);
    tick();
    check("ie0_set", 32'(bus.ie0_o), 32'h1);
    repeat (4) tick();
    check("ie0_hold", 32'(bus.ie0_o), 32'h1);
    bus.ie0_clr_i = 1'b1; tick(); bus.ie0_clr_i = 1'b0;
    check("ie0_cleared", 32'(bus.ie0_o), 32'h0);
    bus.top_p3_y_i[2] = 1'b1; repeat (8) tick();

    // INT1 edge mode: acknowledge coincides with the set
    bus.top_p3_y_i[3] = 1'b0;
    repeat (5) tick();
    bus.ie1_clr_i = 1'b1; tick(); bus.ie1_clr_i = 1'b0;
    check("set_wins", 32'(bus.ie1_o), 32'h1);
    tick();
    check("set_wins_hold", 32'(bus.ie1_o), 32'h1);
    bus.ie1_clr_i = 1'b1; tick(); bus.ie1_clr_i = 1'b0;
    check("ie1_cleared", 32'(bus.ie1_o), 32'h0);
    bus.top_p3_y_i[3] = 1'b1; repeat (8) tick();

    // INT1 level mode
    bus.it1_i = 1'b0; tick();
    bus.top_p3_y_i[3] = 1'b0;
    repeat (5) tick();
    check("lvl_pre", 32'(bus.ie1_o), 32'h0);
    tick();
    check("lvl_low", 32'(bus.ie1_o), 32'h1);
    bus.top_p3_y_i[3] = 1'b1;
    bus.ie1_clr_i = 1'b1; tick(); bus.ie1_clr_i = 1'b0;
    check("lvl_ignores_clr", 32'(bus.ie1_o), 32'h1);
    repeat (4) tick();
    check("lvl_still_low", 32'(bus.ie1_o), 32'h1);
    tick();
    check("lvl_released", 32'(bus.ie1_o), 32'h0);

    // Timer pulses on P3.4
    t0_cnt = 0; t1_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      bus.top_p3_y_i[4] = 1'b0;
      tick(); tick();
      check("t0_early", 32'(bus.t0_pulse_o), 32'h0);
      tick();
      check("t0_pulse_at3", 32'(bus.t0_pulse_o), 32'h1);
      tick();
      check("t0_one_wide", 32'(bus.t0_pulse_o), 32'h0);
      bus.top_p3_y_i[4] = 1'b1;
      repeat (4) tick();
    end
    check("t0_count", 32'(t0_cnt), 32'd3);
    check("t1_count", 32'(t1_cnt), 32'd0);

    // Randomized operation including mid-run resets
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      bus.top_p0_y_i = 8'($urandom);
      bus.top_p1_y_i = 8'($urandom);
      bus.top_p2_y_i = 8'($urandom);
      p3 = bus.top_p3_y_i;
      p3[1:0] = 2'($urandom);
      p3[7:6] = 2'($urandom);
      for (int b = 2; b < 6; b++) if ($urandom_range(0, 5) == 0) p3[b] = ~p3[b];
      bus.top_p3_y_i = p3;
      if ($urandom_range(0, 19) == 0) bus.it0_i = ~bus.it0_i;
      if ($urandom_range(0, 19) == 0) bus.it1_i = ~bus.it1_i;
      bus.ie0_clr_i = ($urandom_range(0, 7) == 0);
      bus.ie1_clr_i = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
